greyscaler_stream: RTL and testbench

AXI4-Stream video greyscale core, parametrised successor of the single-config greyscaler. Takes RGB video, with PPC pixels per beat and PIXEL_WIDTH bits per component. Outputs greyscale replicated into R/G/B, so the downstream video format is unchanged. Mode and coefficients are runtime-selectable, latched per frame, with line-length error checking and a frame counter. Sits between the video input bridge and the framebuffer writer; config comes from the AXI-Lite register block.

---
 rtl/greyscaler_pkg.sv | 35 +++
 rtl/greyscaler_pixel.sv | 83 ++++++++
 rtl/greyscaler_stream.sv | 184 ++++++++++++++++++
 tb/tb_greyscaler_stream.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/greyscaler_pkg.sv
// Shared types and constants for the streaming greyscale core.
package greyscaler_pkg;

    typedef enum logic [1:0] {
        MODE_BYPASS   = 2'd0,
        MODE_WEIGHTED = 2'd1,
        MODE_AVERAGE  = 2'd2,
        MODE_THRESH   = 2'd3
    } mode_t;

    // Equal-weight coefficients expressed at 8 fractional bits (sum = 256).
    localparam int AVG_COEF_R     = 85;
    localparam int AVG_COEF_G     = 86;
    localparam int AVG_COEF_B     = 85;
    localparam int AVG_COEF_SCALE = 8;

    // Reference layout of one 8-bit-per-component pixel.
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel8_t;

    function automatic int acc_width(input int pixel_width, input int coef_width);
        return pixel_width + coef_width + 2;
    endfunction

    function automatic int scale_avg_coef(input int base, input int coef_width);
        if (coef_width >= AVG_COEF_SCALE) begin
            return base << (coef_width - AVG_COEF_SCALE);
        end
        return base >> (AVG_COEF_SCALE - coef_width);
    endfunction

endpackage

// File: rtl/greyscaler_pixel.sv
// One pixel lane: S1 multiply, S2 sum with rounding, S3 mode select and saturation.
module greyscaler_pixel
    import greyscaler_pkg::*;
#(
    parameter int PIXEL_WIDTH = 8,
    parameter int COEF_WIDTH  = 8
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     en1,
    input  logic                     en2,
    input  logic                     en3,
    input  logic [3*PIXEL_WIDTH-1:0] pixel_in,
    input  logic [COEF_WIDTH-1:0]    coef_r,
    input  logic [COEF_WIDTH-1:0]    coef_g,
    input  logic [COEF_WIDTH-1:0]    coef_b,
    input  mode_t                    mode_s2,
    input  logic [PIXEL_WIDTH-1:0]   threshold_s2,
    output logic [3*PIXEL_WIDTH-1:0] pixel_out
);

    localparam int PROD_W = PIXEL_WIDTH + COEF_WIDTH;
    localparam int ACC_W  = acc_width(PIXEL_WIDTH, COEF_WIDTH);
    localparam logic [ACC_W-1:0]       ROUND = ACC_W'(1) << (COEF_WIDTH - 1);
    localparam logic [PIXEL_WIDTH-1:0] Y_MAX = '1;

    logic [PIXEL_WIDTH-1:0]   r_in;
    logic [PIXEL_WIDTH-1:0]   g_in;
    logic [PIXEL_WIDTH-1:0]   b_in;
    logic [PROD_W-1:0]        prod_r_reg;
    logic [PROD_W-1:0]        prod_g_reg;
    logic [PROD_W-1:0]        prod_b_reg;
    logic [3*PIXEL_WIDTH-1:0] raw1_reg;
    logic [3*PIXEL_WIDTH-1:0] raw2_reg;
    logic [ACC_W-1:0]         acc_reg;
    logic [3*PIXEL_WIDTH-1:0] out_reg;
    logic [ACC_W-1:0]         y_full;
    logic [PIXEL_WIDTH-1:0]   y_sat;
    logic [3*PIXEL_WIDTH-1:0] out_next;

    assign r_in = pixel_in[3*PIXEL_WIDTH-1:2*PIXEL_WIDTH];
    assign g_in = pixel_in[2*PIXEL_WIDTH-1:PIXEL_WIDTH];
    assign b_in = pixel_in[PIXEL_WIDTH-1:0];

    always_comb begin
        y_full = acc_reg >> COEF_WIDTH;
        y_sat  = (y_full > ACC_W'(Y_MAX)) ? Y_MAX : y_full[PIXEL_WIDTH-1:0];
        case (mode_s2)
            MODE_BYPASS: out_next = raw2_reg;
            MODE_THRESH: out_next = (y_sat >= threshold_s2) ? '1 : '0;
            default:     out_next = {3{y_sat}};
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            prod_r_reg <= '0;
            prod_g_reg <= '0;
            prod_b_reg <= '0;
            raw1_reg   <= '0;
            raw2_reg   <= '0;
            acc_reg    <= '0;
            out_reg    <= '0;
        end else begin
            if (en1) begin
                prod_r_reg <= PROD_W'(r_in) * PROD_W'(coef_r);
                prod_g_reg <= PROD_W'(g_in) * PROD_W'(coef_g);
                prod_b_reg <= PROD_W'(b_in) * PROD_W'(coef_b);
                raw1_reg   <= pixel_in;
            end
            if (en2) begin
                acc_reg  <= ACC_W'(prod_r_reg) + ACC_W'(prod_g_reg) + ACC_W'(prod_b_reg) + ROUND;
                raw2_reg <= raw1_reg;
            end
            if (en3) begin
                out_reg <= out_next;
            end
        end
    end

    assign pixel_out = out_reg;

endmodule

// File: rtl/greyscaler_stream.sv
// AXI4-Stream greyscale core: PPC lanes, per-frame config latch, line-length checks, frame counter.
module greyscaler_stream
    import greyscaler_pkg::*;
#(
    parameter int PIXEL_WIDTH = 8,
    parameter int PPC         = 1,
    parameter int COEF_WIDTH  = 8,
    parameter int MAX_LINE    = 4096
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    input  logic [3*PIXEL_WIDTH*PPC-1:0]   s_axis_tdata,
    input  logic                           s_axis_tvalid,
    output logic                           s_axis_tready,
    input  logic                           s_axis_tuser,
    input  logic                           s_axis_tlast,
    output logic [3*PIXEL_WIDTH*PPC-1:0]   m_axis_tdata,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic                           m_axis_tuser,
    output logic                           m_axis_tlast,
    input  logic [1:0]                     cfg_mode,
    input  logic [COEF_WIDTH-1:0]          cfg_coef_r,
    input  logic [COEF_WIDTH-1:0]          cfg_coef_g,
    input  logic [COEF_WIDTH-1:0]          cfg_coef_b,
    input  logic [PIXEL_WIDTH-1:0]         cfg_threshold,
    input  logic [$clog2(MAX_LINE):0]      cfg_line_beats,
    input  logic                           err_clear,
    output logic                           err_eol_early,
    output logic                           err_eol_late,
    output logic [31:0]                    frame_count
);

    localparam int PX_W   = 3 * PIXEL_WIDTH;
    localparam int LINE_W = $clog2(MAX_LINE) + 1;
    localparam logic [COEF_WIDTH-1:0] AVG_R = COEF_WIDTH'(scale_avg_coef(AVG_COEF_R, COEF_WIDTH));
    localparam logic [COEF_WIDTH-1:0] AVG_G = COEF_WIDTH'(scale_avg_coef(AVG_COEF_G, COEF_WIDTH));
    localparam logic [COEF_WIDTH-1:0] AVG_B = COEF_WIDTH'(scale_avg_coef(AVG_COEF_B, COEF_WIDTH));

    logic en1, en2, en3, accept;
    logic valid1_reg, valid2_reg, valid3_reg;
    logic user1_reg, user2_reg, user3_reg;
    logic last1_reg, last2_reg, last3_reg;
    mode_t mode1_reg, mode2_reg;
    logic [PIXEL_WIDTH-1:0] thr1_reg, thr2_reg;

    mode_t                  mode_reg;
    logic [COEF_WIDTH-1:0]  coef_r_reg, coef_g_reg, coef_b_reg;
    logic [PIXEL_WIDTH-1:0] thr_reg;
    logic [LINE_W-1:0]      line_beats_reg;
    logic [LINE_W-1:0]      beat_cnt_reg, beat_cnt_next;
    logic                   err_early_reg, err_late_reg;
    logic [31:0]            frame_count_reg;

    mode_t                  eff_mode;
    logic [COEF_WIDTH-1:0]  eff_coef_r, eff_coef_g, eff_coef_b;
    logic [COEF_WIDTH-1:0]  coef_sel_r, coef_sel_g, coef_sel_b;
    logic [PIXEL_WIDTH-1:0] eff_thr;
    logic [LINE_W-1:0]      eff_line_beats;
    logic [LINE_W-1:0]      beat_num;
    logic                   check_en, early_set, late_set;

    // A stage may load whenever the stage after it is empty or draining this cycle.
    assign en3           = !valid3_reg || m_axis_tready;
    assign en2           = !valid2_reg || en3;
    assign en1           = !valid1_reg || en2;
    assign s_axis_tready = en1 && !ARESET;
    assign accept        = s_axis_tvalid && s_axis_tready;

    // The SOF beat itself already uses the incoming configuration.
    always_comb begin
        eff_mode       = s_axis_tuser ? mode_t'(cfg_mode) : mode_reg;
        eff_coef_r     = s_axis_tuser ? cfg_coef_r : coef_r_reg;
        eff_coef_g     = s_axis_tuser ? cfg_coef_g : coef_g_reg;
        eff_coef_b     = s_axis_tuser ? cfg_coef_b : coef_b_reg;
        eff_thr        = s_axis_tuser ? cfg_threshold : thr_reg;
        eff_line_beats = s_axis_tuser ? cfg_line_beats : line_beats_reg;
        coef_sel_r     = (eff_mode == MODE_AVERAGE) ? AVG_R : eff_coef_r;
        coef_sel_g     = (eff_mode == MODE_AVERAGE) ? AVG_G : eff_coef_g;
        coef_sel_b     = (eff_mode == MODE_AVERAGE) ? AVG_B : eff_coef_b;

        beat_num  = (s_axis_tuser ? '0 : beat_cnt_reg) + LINE_W'(1);
        check_en  = (eff_line_beats != '0);
        early_set = accept && s_axis_tlast && check_en && (beat_num < eff_line_beats);
        late_set  = accept && !s_axis_tlast && check_en && (beat_num >= eff_line_beats);
        if (s_axis_tlast) begin
            beat_cnt_next = '0;
        end else if (late_set) begin
            beat_cnt_next = eff_line_beats;
        end else begin
            beat_cnt_next = beat_num;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            valid1_reg <= 1'b0; valid2_reg <= 1'b0; valid3_reg <= 1'b0;
            user1_reg  <= 1'b0; user2_reg  <= 1'b0; user3_reg  <= 1'b0;
            last1_reg  <= 1'b0; last2_reg  <= 1'b0; last3_reg  <= 1'b0;
            mode1_reg  <= MODE_BYPASS;
            mode2_reg  <= MODE_BYPASS;
            thr1_reg   <= '0;
            thr2_reg   <= '0;
        end else begin
            if (en1) begin
                valid1_reg <= s_axis_tvalid;
                user1_reg  <= s_axis_tvalid && s_axis_tuser;
                last1_reg  <= s_axis_tvalid && s_axis_tlast;
                mode1_reg  <= eff_mode;
                thr1_reg   <= eff_thr;
            end
            if (en2) begin
                valid2_reg <= valid1_reg;
                user2_reg  <= user1_reg;
                last2_reg  <= last1_reg;
                mode2_reg  <= mode1_reg;
                thr2_reg   <= thr1_reg;
            end
            if (en3) begin
                valid3_reg <= valid2_reg;
                user3_reg  <= user2_reg;
                last3_reg  <= last2_reg;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            mode_reg        <= MODE_BYPASS;
            coef_r_reg      <= '0;
            coef_g_reg      <= '0;
            coef_b_reg      <= '0;
            thr_reg         <= '0;
            line_beats_reg  <= '0;
            beat_cnt_reg    <= '0;
            err_early_reg   <= 1'b0;
            err_late_reg    <= 1'b0;
            frame_count_reg <= '0;
        end else begin
            if (accept && s_axis_tuser) begin
                mode_reg        <= eff_mode;
                coef_r_reg      <= eff_coef_r;
                coef_g_reg      <= eff_coef_g;
                coef_b_reg      <= eff_coef_b;
                thr_reg         <= eff_thr;
                line_beats_reg  <= eff_line_beats;
                frame_count_reg <= frame_count_reg + 32'd1;
            end
            if (accept) begin
                beat_cnt_reg <= beat_cnt_next;
            end
            err_early_reg <= (err_early_reg && !err_clear) || early_set;
            err_late_reg  <= (err_late_reg && !err_clear) || late_set;
        end
    end

    for (genvar gi = 0; gi < PPC; gi++) begin : g_lane
        greyscaler_pixel #(
            .PIXEL_WIDTH(PIXEL_WIDTH),
            .COEF_WIDTH (COEF_WIDTH)
        ) u_pixel (
            .clk         (ACLK),
            .srst        (ARESET),
            .en1         (en1),
            .en2         (en2),
            .en3         (en3),
            .pixel_in    (s_axis_tdata[gi*PX_W +: PX_W]),
            .coef_r      (coef_sel_r),
            .coef_g      (coef_sel_g),
            .coef_b      (coef_sel_b),
            .mode_s2     (mode2_reg),
            .threshold_s2(thr2_reg),
            .pixel_out   (m_axis_tdata[gi*PX_W +: PX_W])
        );
    end

    assign m_axis_tvalid = valid3_reg;
    assign m_axis_tuser  = user3_reg;
    assign m_axis_tlast  = last3_reg;
    assign err_eol_early = err_early_reg;
    assign err_eol_late  = err_late_reg;
    assign frame_count   = frame_count_reg;

endmodule

// File: tb/tb_greyscaler_stream.sv
// Directed bench for greyscaler_stream with four 8-bit pixels per beat.
module tb_greyscaler_stream;
    import greyscaler_pkg::*;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic [95:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        s_axis_tuser = 1'b0;
    logic        s_axis_tlast = 1'b0;
    logic [95:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tuser;
    logic        m_axis_tlast;
    logic [1:0]  cfg_mode = '0;
    logic [7:0]  cfg_coef_r = '0;
    logic [7:0]  cfg_coef_g = '0;
    logic [7:0]  cfg_coef_b = '0;
    logic [7:0]  cfg_threshold = '0;
    logic [12:0] cfg_line_beats = '0;
    logic        err_clear = 1'b0;
    logic        err_eol_early;
    logic        err_eol_late;
    logic [31:0] frame_count;

    greyscaler_stream #(
        .PIXEL_WIDTH(8), .PPC(4), .COEF_WIDTH(8), .MAX_LINE(4096)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
        .cfg_mode(cfg_mode), .cfg_coef_r(cfg_coef_r), .cfg_coef_g(cfg_coef_g), .cfg_coef_b(cfg_coef_b),
        .cfg_threshold(cfg_threshold), .cfg_line_beats(cfg_line_beats),
        .err_clear(err_clear), .err_eol_early(err_eol_early), .err_eol_late(err_eol_late),
        .frame_count(frame_count)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [95:0] data;
        logic        user;
        logic        last;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          last_latency = 0;
    int          sof_model = 0;
    logic        stall_pending = 1'b0;
    logic [98:0] held = '0;
    logic        accepted = 1'b0;
    logic        rand_ready = 1'b0;
    logic [95:0] next_exp = '0;
    int          m_mode = 0, m_cr = 0, m_cg = 0, m_cb = 0, m_thr = 0;

    task automatic check(input string tag, input logic [99:0] obs, input logic [99:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [23:0] model_px(input logic [23:0] p);
        pixel8_t px;
        int cr, cg, cb, y;
        px = p;
        if (m_mode == 0) return p;
        cr = m_cr; cg = m_cg; cb = m_cb;
        if (m_mode == 2) begin cr = 85; cg = 86; cb = 85; end
        y = (int'(px.r) * cr + int'(px.g) * cg + int'(px.b) * cb + 128) / 256;
        if (y > 255) y = 255;
        if (m_mode == 3) return (y >= m_thr) ? 24'hFFFFFF : 24'h000000;
        return {3{8'(y)}};
    endfunction

    function automatic logic [95:0] model_beat(input logic [95:0] d);
        logic [95:0] o;
        for (int l = 0; l < 4; l++) o[l*24 +: 24] = model_px(d[l*24 +: 24]);
        return o;
    endfunction

    // One clock: check outputs and handshakes just after the falling edge, then wait a cycle.
    task automatic step();
        exp_t e;
        if (rand_ready) m_axis_tready = 1'($urandom_range(0, 1));
        #1;
        if (stall_pending)
            check("stall_hold", 100'({m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata}), 100'(held));
        if (m_axis_tvalid && m_axis_tready) begin
            check("output_pending", 100'(exp_q.size() != 0), 100'(1));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("out_data", 100'(m_axis_tdata), 100'(e.data));
                check("out_user", 100'(m_axis_tuser), 100'(e.user));
                check("out_last", 100'(m_axis_tlast), 100'(e.last));
                last_latency = cyc - e.cyc;
            end
        end
        stall_pending = m_axis_tvalid && !m_axis_tready;
        held = {m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata};
        if (s_axis_tvalid && s_axis_tready) begin
            e.data = next_exp; e.user = s_axis_tuser; e.last = s_axis_tlast; e.cyc = cyc;
            exp_q.push_back(e);
            accepted = 1'b1;
            if (s_axis_tuser) sof_model++;
        end
        cyc++;
        @(negedge ACLK);
    endtask

    task automatic send(input logic [95:0] d, input logic u, input logic l, input logic [95:0] expd);
        int n = 0;
        s_axis_tdata = d; s_axis_tuser = u; s_axis_tlast = l; s_axis_tvalid = 1'b1;
        next_exp = expd;
        accepted = 1'b0;
        while (!accepted && n < 100) begin step(); n++; end
        check("send_accepted", 100'(accepted), 100'(1));
        s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        m_axis_tready = 1'b1;
        while (exp_q.size() != 0 && n < 200) begin step(); n++; end
        check("drain_empty", 100'(exp_q.size()), 100'(0));
    endtask

    task automatic send_line(input int n, input logic sof);
        logic [95:0] d;
        for (int k = 1; k <= n; k++) begin
            d = {4{24'(k)}};
            send(d, sof && (k == 1), k == n, d);
        end
    endtask

    task automatic set_cfg(input int mode, input int cr, input int cg, input int cb, input int thr, input int lb);
        cfg_mode = 2'(mode); cfg_coef_r = 8'(cr); cfg_coef_g = 8'(cg); cfg_coef_b = 8'(cb);
        cfg_threshold = 8'(thr); cfg_line_beats = 13'(lb);
    endtask

    task automatic do_reset();
        ARESET = 1'b1;
        s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0; err_clear = 1'b0;
        @(negedge ACLK);
        #1;
        check("rst_s_tready", 100'(s_axis_tready), 100'(0));
        check("rst_m_tvalid", 100'(m_axis_tvalid), 100'(0));
        check("rst_m_tdata", 100'(m_axis_tdata), 100'(0));
        check("rst_m_tuser_tlast", 100'({m_axis_tuser, m_axis_tlast}), 100'(0));
        check("rst_frame_count", 100'(frame_count), 100'(0));
        check("rst_err_flags", 100'({err_eol_early, err_eol_late}), 100'(0));
        exp_q.delete();
        stall_pending = 1'b0;
        sof_model = 0;
        m_mode = 0; m_cr = 0; m_cg = 0; m_cb = 0; m_thr = 0;
        @(negedge ACLK);
        ARESET = 1'b0;
    endtask

    initial begin
        logic [95:0] d, e, pr;
        logic u, l;

        do_reset();

        // Latched config comes out of reset as bypass, whatever cfg_* shows.
        set_cfg(1, 77, 150, 29, 0, 0);
        d = 96'h123456_ABCDEF_FEDCBA_654321;
        send(d, 1'b0, 1'b0, d);
        drain();

        // Weighted 77/150/29, also measures first-beat latency.
        set_cfg(1, 77, 150, 29, 0, 0);
        send({24'h808080, 24'h000000, 24'hFF0000, 24'hFFFFFF}, 1'b1, 1'b0,
             {24'h808080, 24'h000000, 24'h4D4D4D, 24'hFFFFFF});
        drain();
        check("latency", 100'(last_latency), 100'(3));

        // Saturation with full-scale coefficients.
        set_cfg(1, 255, 255, 255, 0, 0);
        send({24'h808080, 24'h000000, 24'h010101, 24'hFFFFFF}, 1'b1, 1'b0,
             {24'hFFFFFF, 24'h000000, 24'h030303, 24'hFFFFFF});
        drain();

        // Threshold 128, including Y exactly at the threshold.
        set_cfg(3, 77, 150, 29, 128, 0);
        send({24'h7F7F7F, 24'h808080, 24'hFFFFFF, 24'hFF0000}, 1'b1, 1'b0,
             {24'h000000, 24'hFFFFFF, 24'hFFFFFF, 24'h000000});
        drain();

        // Average ignores the programmed coefficients.
        set_cfg(2, 0, 0, 0, 0, 0);
        send({24'h00FF00, 24'hFF0000, 24'h030303, 24'hFFFFFF}, 1'b1, 1'b0,
             {24'h565656, 24'h555555, 24'h030303, 24'hFFFFFF});
        drain();

        // Mid-frame config change waits for the next SOF.
        pr = {4{24'hFF0000}};
        set_cfg(1, 77, 150, 29, 0, 0);
        send(pr, 1'b1, 1'b0, {4{24'h4D4D4D}});
        set_cfg(0, 1, 2, 3, 0, 0);
        send(pr, 1'b0, 1'b0, {4{24'h4D4D4D}});
        send(pr, 1'b0, 1'b1, {4{24'h4D4D4D}});
        send(pr, 1'b1, 1'b0, pr);
        drain();
        check("frame_count_6", 100'(frame_count), 100'(6));

        // Line length checks with 8 expected beats.
        set_cfg(0, 0, 0, 0, 0, 8);
        send_line(5, 1'b1);
        check("eol_early_set", 100'({err_eol_early, err_eol_late}), 100'(2'b10));
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        check("err_cleared", 100'({err_eol_early, err_eol_late}), 100'(2'b00));
        send_line(8, 1'b0);
        check("exact_line_ok", 100'({err_eol_early, err_eol_late}), 100'(2'b00));
        send_line(10, 1'b0);
        check("eol_late_set", 100'({err_eol_early, err_eol_late}), 100'(2'b01));
        err_clear = 1'b1;
        send_line(3, 1'b0);
        err_clear = 1'b0;
        check("set_beats_clear", 100'({err_eol_early, err_eol_late}), 100'(2'b10));
        set_cfg(0, 0, 0, 0, 0, 0);
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        send_line(2, 1'b1);
        check("checks_disabled", 100'({err_eol_early, err_eol_late}), 100'(2'b00));
        drain();

        // Random backpressure stream, 10-beat lines, new random config every 5 lines.
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            u = (i % 50 == 0);
            l = (i % 10 == 9);
            if (u) begin
                set_cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                        int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 10);
                m_mode = int'(cfg_mode); m_cr = int'(cfg_coef_r); m_cg = int'(cfg_coef_g);
                m_cb = int'(cfg_coef_b); m_thr = int'(cfg_threshold);
            end
            d = {$urandom, $urandom, $urandom};
            e = model_beat(d);
            send(d, u, l, e);
        end
        rand_ready = 1'b0;
        drain();
        check("stream_err_flags", 100'({err_eol_early, err_eol_late}), 100'(2'b00));
        check("stream_frame_count", 100'(frame_count), 100'(sof_model));

        // Reset while the pipeline is full and stalled.
        m_axis_tready = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 4);
        send(96'hA, 1'b1, 1'b0, 96'hA);
        send(96'hB, 1'b0, 1'b1, 96'hB);
        send(96'hC, 1'b0, 1'b0, 96'hC);
        check("pre_reset_early", 100'(err_eol_early), 100'(1));
        check("pre_reset_held", 100'({m_axis_tvalid, m_axis_tuser}), 100'(2'b11));
        do_reset();
        m_axis_tready = 1'b1;
        d = 96'h0000AA_0000BB_0000CC_0000DD;
        send(d, 1'b0, 1'b0, d);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
